// File: rtl/fm_pkg.sv
// Shared types, derived widths and the clamp helper for the FM phase-increment generator.
package fm_pkg;

    // Default sizing of the modulator front end.
    localparam int NBITS_DEF       = 13;
    localparam int NBITS_AUDIO_DEF = 12;
    localparam int NBITS_GAIN_DEF  = 8;
    localparam int SHIFT_DEF       = 6;
    localparam int CENTER_INC_DEF  = 1024;
    localparam int ENDIV_DEF       = 4;

    // Product register width (signed audio x unsigned gain, with headroom) and clamp-sum width.
    localparam int ACC_W = NBITS_AUDIO_DEF + NBITS_GAIN_DEF + 1;
    localparam int SUM_W = ACC_W + 1;

    // Largest legal phase increment, held in the signed sum width for comparison.
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((1 << NBITS_DEF) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        CLAMP  = 2'd2,
        UPDATE = 2'd3
    } state_e;

    typedef struct packed {
        logic                 sat;
        logic [NBITS_DEF-1:0] val;
    } clamp_t;

    // Clamp a signed sum into [0, 2^NBITS-1] and report whether clamping happened.
    function automatic clamp_t sat_limit(input logic signed [SUM_W-1:0] sum);
        clamp_t r;
        if (sum[SUM_W-1]) begin
            r.sat = 1'b1;
            r.val = '0;
        end else if (sum > SUM_MAX) begin
            r.sat = 1'b1;
            r.val = '1;
        end else begin
            r.sat = 1'b0;
            r.val = sum[NBITS_DEF-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_su.sv
// Sequential signed x unsigned shift-add multiplier: one multiplier bit per clock.
module seq_mult_su #(
    parameter int NBITS_A = 12,
    parameter int NBITS_B = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic signed [NBITS_A-1:0]  a_i,
    input  logic [NBITS_B-1:0]         b_i,
    output logic                       done_o,
    output logic signed [NBITS_A+NBITS_B:0] product_o
);

    localparam int PW    = NBITS_A + NBITS_B + 1;
    localparam int CNT_W = $clog2(NBITS_B);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS_B - 1);

    logic signed [NBITS_A-1:0] a_q, a_d;
    logic [NBITS_B-1:0]        b_q, b_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [PW-1:0]      acc_q, acc_d;
    logic                      run_q, run_d;
    logic signed [PW-1:0]      a_ext_s;
    logic signed [PW-1:0]      term_s;

    assign a_ext_s   = PW'(a_q);
    assign term_s    = a_ext_s <<< cnt_q;
    // done is high during the cycle that processes the final multiplier bit
    assign done_o    = run_q && (cnt_q == CNT_LAST);
    assign product_o = acc_q;

    // Next-state: load operands on start, otherwise accumulate one partial product per cycle.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        run_d = run_q;
        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            cnt_d = '0;
            acc_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (b_q[cnt_q]) begin
                acc_d = acc_q + term_s;
            end else begin
                acc_d = acc_q;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                run_d = 1'b0;
            end else begin
                run_d = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            run_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/fm_phaseinc_gen.sv
// FM modulator front end: scales audio by a deviation gain, offsets the carrier
// increment, clamps it for the DDS and generates the DDS enable strobe.
module fm_phaseinc_gen
    import fm_pkg::*;
#(
    parameter int NBITS       = NBITS_DEF,
    parameter int NBITS_AUDIO = NBITS_AUDIO_DEF,
    parameter int NBITS_GAIN  = NBITS_GAIN_DEF,
    parameter int SHIFT       = SHIFT_DEF,
    parameter int CENTER_INC  = CENTER_INC_DEF,
    parameter int ENDIV       = ENDIV_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic signed [NBITS_AUDIO-1:0] audio_in,
    input  logic                          audio_valid,
    output logic                          audio_ready,
    input  logic [NBITS_GAIN-1:0]         gain,
    output logic [NBITS-1:0]              phaseinc,
    output logic                          enableclk,
    output logic                          sat,
    output logic                          busy
);

    localparam int DIV_W = (ENDIV > 2) ? $clog2(ENDIV) : 1;
    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(ENDIV - 1);
    localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(CENTER_INC);

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    enableclk_q;
    state_e                  state_q;
    logic [NBITS-1:0]        phaseinc_q;
    logic [NBITS-1:0]        result_q;
    logic                    sat_pend_q;
    logic                    sat_q;
    logic                    busy_q;
    logic                    ready_q;
    logic                    mul_start_s;
    logic                    mul_done_s;
    logic signed [ACC_W-1:0] product_s;
    logic signed [ACC_W-1:0] scaled_s;
    logic signed [SUM_W-1:0] sum_s;
    clamp_t                  clamp_d;

    assign audio_ready = ready_q;
    assign busy        = busy_q;
    assign sat         = sat_q;
    assign phaseinc    = phaseinc_q;
    assign enableclk   = enableclk_q;

    assign mul_start_s = (state_q == IDLE) && ready_q && audio_valid;

    seq_mult_su #(
        .NBITS_A (NBITS_AUDIO),
        .NBITS_B (NBITS_GAIN)
    ) u_mult (
        .clock     (clock),
        .reset     (reset),
        .start_i   (mul_start_s),
        .a_i       (audio_in),
        .b_i       (gain),
        .done_o    (mul_done_s),
        .product_o (product_s)
    );

    // Free-running mod-ENDIV divider next count.
    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register and registered enable strobe (high while count == ENDIV-1).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            enableclk_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            enableclk_q <= (div_d == DIV_LAST);
        end
    end

    // Scale the product (floor shift), add the centre increment and clamp.
    always_comb begin
        scaled_s = product_s >>> SHIFT;
        sum_s    = SUM_W'(scaled_s) + CENTER_S;
        clamp_d  = sat_limit(sum_s);
    end

    // Control FSM with registered handshake, busy, sat and phaseinc outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            phaseinc_q <= NBITS'(CENTER_INC);
            result_q   <= NBITS'(CENTER_INC);
            sat_pend_q <= 1'b0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            sat_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mul_start_s) begin
                        state_q <= MUL;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MUL: begin
                    if (mul_done_s) begin
                        state_q <= CLAMP;
                    end else begin
                        state_q <= MUL;
                    end
                end
                CLAMP: begin
                    result_q   <= clamp_d.val;
                    sat_pend_q <= clamp_d.sat;
                    state_q    <= UPDATE;
                end
                UPDATE: begin
                    phaseinc_q <= result_q;
                    sat_q      <= sat_pend_q;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm_phaseinc_gen.sv
// Directed, table-driven bench for fm_phaseinc_gen with hand-computed expectations.
module tb_fm_phaseinc_gen;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic signed [11:0] audio_in = '0;
    logic               audio_valid = 1'b0;
    logic               audio_ready;
    logic [7:0]         gain = '0;
    logic [12:0]        phaseinc;
    logic               enableclk;
    logic               sat;
    logic               busy;

    int          total = 0;
    int          bad   = 0;
    logic [12:0] model_pi;

    typedef struct {
        logic signed [11:0] audio;
        logic [7:0]         gain;
        logic [12:0]        exp_pi;
        logic               exp_sat;
    } vec_t;

    vec_t vecs[9];

    fm_phaseinc_gen dut (
        .clock       (clock),
        .reset       (reset),
        .audio_in    (audio_in),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .gain        (gain),
        .phaseinc    (phaseinc),
        .enableclk   (enableclk),
        .sat         (sat),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One sample through the handshake, checking the full 11-cycle window.
    task automatic run_vec(input logic signed [11:0] a, input logic [7:0] g,
                           input logic [12:0] exp_pi, input logic exp_sat, input string name);
        int waited;
        waited = 0;
        audio_in    = a;
        gain        = g;
        audio_valid = 1'b1;
        while (!audio_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk({name, " ready_before"}, 32'(audio_ready), 32'd1);
        tick();
        audio_valid = 1'b0;
        audio_in    = 12'sd2047;
        gain        = 8'd255;
        for (int k = 1; k <= 10; k++) begin
            chk({name, " ready_low"}, 32'(audio_ready), 32'd0);
            chk({name, " busy_high"}, 32'(busy), 32'd1);
            chk({name, " phaseinc_hold"}, 32'(phaseinc), 32'(model_pi));
            tick();
        end
        chk({name, " phaseinc"}, 32'(phaseinc), 32'(exp_pi));
        chk({name, " sat"}, 32'(sat), 32'(exp_sat));
        chk({name, " ready_back"}, 32'(audio_ready), 32'd1);
        chk({name, " busy_low"}, 32'(busy), 32'd0);
        tick();
        chk({name, " sat_pulse_end"}, 32'(sat), 32'd0);
        chk({name, " phaseinc_after"}, 32'(phaseinc), 32'(exp_pi));
        model_pi = exp_pi;
    endtask

    initial begin
        vecs[0] = '{12'sd256,   8'd128, 13'd1536, 1'b0};
        vecs[1] = '{-12'sd256,  8'd128, 13'd512,  1'b0};
        vecs[2] = '{-12'sd1,    8'd1,   13'd1023, 1'b0};
        vecs[3] = '{-12'sd2048, 8'd255, 13'd0,    1'b1};
        vecs[4] = '{12'sd2047,  8'd255, 13'd8191, 1'b1};
        vecs[5] = '{12'sd100,   8'd0,   13'd1024, 1'b0};
        vecs[6] = '{12'sd1000,  8'd64,  13'd2024, 1'b0};
        vecs[7] = '{-12'sd3,    8'd3,   13'd1023, 1'b0};
        vecs[8] = '{12'sd5,     8'd200, 13'd1039, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst phaseinc", 32'(phaseinc), 32'd1024);
        chk("rst ready", 32'(audio_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sat", 32'(sat), 32'd0);
        chk("rst enableclk", 32'(enableclk), 32'd0);
        reset = 1'b1;

        // enableclk every 4th clock after release, idle outputs steady
        for (int n = 1; n <= 12; n++) begin
            tick();
            chk($sformatf("enableclk n=%0d", n), 32'(enableclk), 32'((n % 4) == 3));
            chk($sformatf("idle phaseinc n=%0d", n), 32'(phaseinc), 32'd1024);
            chk($sformatf("idle ready n=%0d", n), 32'(audio_ready), 32'd1);
        end
        model_pi = 13'd1024;

        // Table of single samples
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i].audio, vecs[i].gain, vecs[i].exp_pi, vecs[i].exp_sat,
                    $sformatf("vec%0d", i));
        end

        // valid held high with data changing while busy: only IDLE samples are taken
        audio_in    = 12'sd256;
        gain        = 8'd128;
        audio_valid = 1'b1;
        chk("hold ready0", 32'(audio_ready), 32'd1);
        tick();
        for (int k = 0; k < 10; k++) begin
            audio_in = 12'(k * 200 - 900);
            gain     = 8'(255 - k);
            chk("hold ready_low1", 32'(audio_ready), 32'd0);
            chk("hold phaseinc_old", 32'(phaseinc), 32'(model_pi));
            tick();
        end
        chk("hold ready1", 32'(audio_ready), 32'd1);
        chk("hold phaseinc1", 32'(phaseinc), 32'd1536);
        audio_in = -12'sd256;
        gain     = 8'd128;
        tick();
        for (int k = 0; k < 10; k++) begin
            audio_in = 12'(2047 - k * 300);
            gain     = 8'(200 + k);
            chk("hold ready_low2", 32'(audio_ready), 32'd0);
            chk("hold phaseinc_mid", 32'(phaseinc), 32'd1536);
            tick();
        end
        chk("hold phaseinc2", 32'(phaseinc), 32'd512);
        chk("hold ready2", 32'(audio_ready), 32'd1);
        audio_valid = 1'b0;
        model_pi    = 13'd512;
        tick();

        // Reset during MUL aborts the update
        audio_in    = 12'sd256;
        gain        = 8'd128;
        audio_valid = 1'b1;
        tick();
        audio_valid = 1'b0;
        tick();
        tick();
        chk("abort busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort phaseinc", 32'(phaseinc), 32'd1024);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(audio_ready), 32'd1);
        chk("abort sat", 32'(sat), 32'd0);
        chk("abort enableclk", 32'(enableclk), 32'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("abort no_update", 32'(phaseinc), 32'd1024);
            chk("abort idle_busy", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule
